// File: rtl/tdm_demux_1_to_4.sv
// TDM 1:4 demultiplexer: locks to a slot-0 sync and presents channels a..d as one registered frame.
// Optional misplaced-sync realignment and sync_err pulse enabled by defining TDM_SYNC_CHECK_EN.
//
// state | meaning
// HUNT  | waiting for a valid sample with sync=1 to mark slot 0
// LOCK  | aligned; slots counted on valid samples, frame emitted at slot 3
module tdm_demux_1_to_4 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sync,
    output logic             s0,
    output logic             s1,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic {HUNT, LOCK} state_t;

    state_t           state, state_nxt;
    logic [1:0]       slot, slot_nxt;
    logic [WIDTH-1:0] sh0, sh1, sh2;
    logic [WIDTH-1:0] sh0_nxt, sh1_nxt, sh2_nxt;
    logic [WIDTH-1:0] a_nxt, b_nxt, c_nxt, d_nxt;
    logic             fv_nxt, err_nxt;
    logic             misplaced;

`ifdef TDM_SYNC_CHECK_EN
    assign misplaced = sync && (slot != 2'd0);
`else
    assign misplaced = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            slot        <= 2'd0;
            sh0         <= '0;
            sh1         <= '0;
            sh2         <= '0;
            a           <= '0;
            b           <= '0;
            c           <= '0;
            d           <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_nxt;
            slot        <= slot_nxt;
            sh0         <= sh0_nxt;
            sh1         <= sh1_nxt;
            sh2         <= sh2_nxt;
            a           <= a_nxt;
            b           <= b_nxt;
            c           <= c_nxt;
            d           <= d_nxt;
            frame_valid <= fv_nxt;
            sync_err    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        sh0_nxt   = sh0;
        sh1_nxt   = sh1;
        sh2_nxt   = sh2;
        a_nxt     = a;
        b_nxt     = b;
        c_nxt     = c;
        d_nxt     = d;
        fv_nxt    = 1'b0;
        err_nxt   = 1'b0;
        if (din_valid) begin
            case (state)
                HUNT: begin
                    if (sync) begin
                        sh0_nxt   = din;
                        slot_nxt  = 2'd1;
                        state_nxt = LOCK;
                    end
                end
                LOCK: begin
                    if (misplaced) begin
                        // realign: this sample becomes slot 0, partial frame dropped
                        sh0_nxt  = din;
                        slot_nxt = 2'd1;
                        err_nxt  = 1'b1;
                    end else begin
                        case (slot)
                            2'd0: sh0_nxt = din;
                            2'd1: sh1_nxt = din;
                            2'd2: sh2_nxt = din;
                            2'd3: begin
                                a_nxt  = sh0;
                                b_nxt  = sh1;
                                c_nxt  = sh2;
                                d_nxt  = din;
                                fv_nxt = 1'b1;
                            end
                        endcase
                        slot_nxt = slot + 2'd1;
                    end
                end
            endcase
        end
    end

    assign s0     = slot[0];
    assign s1     = slot[1];
    assign locked = (state == LOCK);

endmodule

// File: tb/tb_tdm_demux_1_to_4.sv
// Scoreboard bench for tdm_demux_1_to_4: frame-level queue model, per-cycle status and frame data checks.
// Follows TDM_SYNC_CHECK_EN so the model matches the build under test.
module tb_tdm_demux_1_to_4;

    localparam int W = 4;
`ifdef TDM_SYNC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         sync = 1'b0;
    logic         s0, s1, frame_valid, locked, sync_err;
    logic [W-1:0] a, b, c, d;

    tdm_demux_1_to_4 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
        .s0(s0), .s1(s1), .a(a), .b(b), .c(c), .d(d),
        .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] slot;
        logic       lck;
        logic       fv;
        logic       err;
    } exp_t;

    exp_t           cq[$];
    logic [4*W-1:0] fq[$];
    logic [4*W-1:0] last_frame = '0;
    logic [W-1:0]   cur[$];
    bit             m_lock = 1'b0;
    int             n_cmp = 0;
    int             n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: samples accumulate in a queue from the sync onwards; four of them make a frame.
    task automatic step(input logic dv, input logic s, input logic [W-1:0] v);
        exp_t e;
        @(posedge clk);
        #2;
        din_valid = dv;
        sync      = s;
        din       = v;
        e = '0;
        if (dv) begin
            if (!m_lock) begin
                if (s) begin
                    cur = {v};
                    m_lock = 1'b1;
                end
            end else if (CHK && s && cur.size() != 0) begin
                cur = {v};
                e.err = 1'b1;
            end else begin
                cur.push_back(v);
                if (cur.size() == 4) begin
                    fq.push_back({cur[0], cur[1], cur[2], cur[3]});
                    cur.delete();
                    e.fv = 1'b1;
                end
            end
        end
        e.slot = 2'(cur.size());
        e.lck  = m_lock;
        cq.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        din_valid = 1'b0;
        sync      = 1'b0;
        rst       = 1'b1;
        #1;
        chk("rst_a", 32'(a), 0);
        chk("rst_b", 32'(b), 0);
        chk("rst_c", 32'(c), 0);
        chk("rst_d", 32'(d), 0);
        chk("rst_slot", {30'd0, s1, s0}, 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_fv", 32'(frame_valid), 0);
        chk("rst_err", 32'(sync_err), 0);
        m_lock = 1'b0;
        cur.delete();
        fq.delete();
        cq.delete();
        last_frame = '0;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (cq.size() > 0) begin
            e = cq.pop_front();
            chk("slot", {30'd0, s1, s0}, 32'(e.slot));
            chk("locked", 32'(locked), 32'(e.lck));
            chk("frame_valid", 32'(frame_valid), 32'(e.fv));
            chk("sync_err", 32'(sync_err), 32'(e.err));
            if (frame_valid) begin
                if (fq.size() == 0) chk("frame_unexpected", 1, 0);
                else last_frame = fq.pop_front();
            end
            chk("frame_data", 32'({a, b, c, d}), 32'(last_frame));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic dv, s;
        do_reset();
        // lock and first frame
        step(1, 1, 4'h1); step(1, 0, 4'h0); step(1, 0, 4'h0); step(1, 0, 4'h1);
        step(0, 0, 4'h0); step(0, 0, 4'h0);
        // hunt drop
        do_reset();
        step(1, 0, 4'hF); step(1, 0, 4'hE);
        step(1, 1, 4'h0); step(1, 0, 4'h1); step(1, 0, 4'h0); step(1, 0, 4'h0);
        step(0, 0, 4'h0);
        // stalls between samples
        begin
            logic [W-1:0] fr[4];
            fr[0] = 4'h1; fr[1] = 4'h0; fr[2] = 4'h1; fr[3] = 4'h0;
            for (int i = 0; i < 4; i++) begin
                step(1, i == 0, fr[i]);
                for (int k = 0; k < 3; k++) step(0, 1, 4'h5);
            end
        end
        // back-to-back frames, sync on first only
        for (int i = 0; i < 12; i++) step(1, i == 0, 4'($urandom));
        step(0, 0, 4'h0);
        // misplaced sync at slot 2
        step(1, 1, 4'h3); step(1, 0, 4'h4); step(1, 1, 4'h5);
        for (int i = 0; i < 6; i++) step(1, 0, 4'(i + 6));
        step(0, 0, 4'h0);
        // mid-frame reset then recovery
        step(1, 1, 4'h9); step(1, 0, 4'hA);
        do_reset();
        step(1, 1, 4'hC); step(1, 0, 4'hD); step(1, 0, 4'hE); step(1, 0, 4'hF);
        step(0, 0, 4'h0);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            dv = ($urandom_range(0, 9) < 7);
            if (!m_lock)             s = ($urandom_range(0, 9) < 3);
            else if (cur.size() == 0) s = ($urandom_range(0, 1) == 1);
            else                     s = ($urandom_range(0, 19) == 0);
            step(dv, s, 4'($urandom));
        end
        step(0, 0, 4'h0);
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("drain_cycles", 32'(cq.size()), 0);
        chk("drain_frames", 32'(fq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
